// File: rtl/esp32_prog_pkg.sv
// Shared definitions for the ESP32 programming sequencer: mode codes, hold FSM
// states and the DTR/RTS to EN/GPIO0 decode used by auto mode.
package esp32_prog_pkg;

    localparam logic [1:0] MODE_AUTO  = 2'd0;
    localparam logic [1:0] MODE_FLASH = 2'd1;
    localparam logic [1:0] MODE_OFF   = 2'd2;
    localparam logic [1:0] MODE_RUN   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_t;

    // {dtr, rts} -> {en, io0}; both-equal states leave the ESP32 running
    function automatic logic [1:0] decode_ctrl(input logic [1:0] ctrl_in);
        case (ctrl_in)
            2'b10:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/esp32_prog_seq_if.sv
// Button readback port: SPI chip select / clock in, shared sd_d[0] pin drive out.
interface esp32_prog_seq_if;

    logic spi_csn;
    logic spi_sck;
    logic sd_d0_out;
    logic sd_d0_oe;

    modport master (output spi_csn, output spi_sck, input sd_d0_out, input sd_d0_oe);
    modport slave  (input spi_csn, input spi_sck, output sd_d0_out, output sd_d0_oe);

endinterface

// File: rtl/esp32_prog_seq_sig_filter.sv
// Synchroniser chain followed by a stability filter; the output only follows the
// synced input after it has differed for C_filter consecutive cycles.
module sig_filter #(
    parameter int C_sync_stages = 2,
    parameter int C_filter      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [7:0] CNT_LOAD = 8'(C_filter - 1);

    logic [C_sync_stages-1:0] sync;
    logic [7:0]               cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
            cnt  <= CNT_LOAD;
            dout <= 1'b1;
        end else begin
            sync <= {sync[C_sync_stages-2:0], din};
            if (sync[C_sync_stages-1] == dout) begin
                cnt <= CNT_LOAD;
            end else if (cnt == 8'd0) begin
                dout <= sync[C_sync_stages-1];
                cnt  <= CNT_LOAD;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/esp32_prog_seq.sv
// ESP32 programming sequencer: filtered DTR/RTS decode into EN/GPIO0, a
// restartable programming-hold timer and oversampled SPI button readback.
module esp32_prog_seq
    import esp32_prog_pkg::*;
#(
    parameter int C_sync_stages  = 2,
    parameter int C_filter       = 8,
    parameter int C_release_bits = 17,
    parameter int C_btn_bits     = 7,
    parameter int C_spi_bits     = 8
) (
    input  logic                  clk_25mhz,
    input  logic                  reset,
    input  logic                  ftdi_ndtr,
    input  logic                  ftdi_nrts,
    input  logic [1:0]            mode,
    input  logic [C_btn_bits-1:0] btn,
    esp32_prog_seq_if.slave       spi,
    output logic                  wifi_en,
    output logic                  wifi_gpio0,
    output logic                  prog_active,
    output logic [7:0]            prog_count
);

    // state | meaning
    // IDLE  | no programming session, hold timer stopped
    // HOLD  | programming session open, timer runs down to release
    localparam logic [C_release_bits-1:0] HOLD_LOAD = '1;

    logic                      dtr_f, rts_f, csn_s, sck_s, sck_d;
    logic [C_btn_bits-1:0]     btn_s;
    logic [C_spi_bits-1:0]     shreg;
    logic [1:0]                in_prev, ctrl;
    hold_state_t               state, state_nxt;
    logic [C_release_bits-1:0] hold_cnt, hold_cnt_nxt;
    logic [7:0]                prog_count_nxt;
    logic                      trigger, en_nxt, io0_nxt, sd_out_nxt, sd_oe_nxt;

    sig_filter #(.C_sync_stages(C_sync_stages), .C_filter(C_filter)) u_dtr (
        .clk(clk_25mhz), .reset(reset), .din(ftdi_ndtr), .dout(dtr_f));
    sig_filter #(.C_sync_stages(C_sync_stages), .C_filter(C_filter)) u_rts (
        .clk(clk_25mhz), .reset(reset), .din(ftdi_nrts), .dout(rts_f));
    sig_filter #(.C_sync_stages(C_sync_stages), .C_filter(1)) u_csn (
        .clk(clk_25mhz), .reset(reset), .din(spi.spi_csn), .dout(csn_s));
    sig_filter #(.C_sync_stages(C_sync_stages), .C_filter(1)) u_sck (
        .clk(clk_25mhz), .reset(reset), .din(spi.spi_sck), .dout(sck_s));

    for (genvar i = 0; i < C_btn_bits; i++) begin : g_btn
        sig_filter #(.C_sync_stages(C_sync_stages), .C_filter(1)) u_btn (
            .clk(clk_25mhz), .reset(reset), .din(btn[i]), .dout(btn_s[i]));
    end

    assign prog_active = (state == ST_HOLD);

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            prog_count    <= '0;
            in_prev       <= 2'b11;
            sck_d         <= 1'b1;
            shreg         <= '0;
            wifi_en       <= 1'b1;
            wifi_gpio0    <= 1'b1;
            spi.sd_d0_out <= 1'b1;
            spi.sd_d0_oe  <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_cnt_nxt;
            prog_count    <= prog_count_nxt;
            in_prev       <= {dtr_f, rts_f};
            sck_d         <= sck_s;
            // Deselect keeps reloading, so a CSn rise beats a coincident SCK rise
            if (csn_s) begin
                shreg <= C_spi_bits'(btn_s);
            end else if (sck_s && !sck_d) begin
                shreg <= {shreg[C_spi_bits-2:0], 1'b0};
            end
            wifi_en       <= en_nxt;
            wifi_gpio0    <= io0_nxt;
            spi.sd_d0_out <= sd_out_nxt;
            spi.sd_d0_oe  <= sd_oe_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        prog_count_nxt = prog_count;
        ctrl           = 2'b11;
        sd_oe_nxt      = 1'b0;
        sd_out_nxt     = 1'b1;
        // 11 -> 10 edge on the filtered lines opens (or restarts) a session
        trigger = (mode == MODE_AUTO) && (in_prev == 2'b11) && ({dtr_f, rts_f} == 2'b10);

        if (trigger) begin
            state_nxt    = ST_HOLD;
            hold_cnt_nxt = HOLD_LOAD;
            if (prog_count != 8'hFF) prog_count_nxt = prog_count + 8'd1;
        end else if (state == ST_HOLD) begin
            if (hold_cnt == '0) state_nxt = ST_IDLE;
            else                hold_cnt_nxt = hold_cnt - C_release_bits'(1);
        end

        case (mode)
            MODE_AUTO:  ctrl = decode_ctrl({dtr_f, rts_f});
            MODE_FLASH: ctrl = {rts_f, dtr_f};
            MODE_OFF:   ctrl = 2'b01;
            default:    ctrl = 2'b11;
        endcase
        en_nxt  = ctrl[1];
        io0_nxt = ctrl[0] & btn_s[0];

        if (prog_active) begin
            sd_oe_nxt  = 1'b1;
            sd_out_nxt = wifi_gpio0;
        end else if (!csn_s) begin
            sd_oe_nxt  = 1'b1;
            sd_out_nxt = shreg[C_spi_bits-1];
        end
    end

endmodule

// File: tb/tb_esp32_prog_seq.sv
// Bench for esp32_prog_seq: cycle-indexed pin history model compared every cycle,
// plus literal checks on reset, filtering, hold timing, SPI readback and modes.
module tb_esp32_prog_seq;

    localparam int C_FILTER = 8;
    localparam int REL_BITS = 11;
    localparam int HOLD_N   = 1 << REL_BITS;
    localparam int MAXC     = 8192;

    logic       clk_25mhz = 1'b0;
    logic       reset;
    logic       ftdi_ndtr, ftdi_nrts;
    logic [1:0] mode;
    logic [6:0] btn;
    logic       wifi_en, wifi_gpio0, prog_active;
    logic [7:0] prog_count;

    esp32_prog_seq_if sif ();

    esp32_prog_seq #(
        .C_sync_stages(2), .C_filter(C_FILTER), .C_release_bits(REL_BITS),
        .C_btn_bits(7), .C_spi_bits(8)
    ) dut (
        .clk_25mhz(clk_25mhz), .reset(reset), .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts),
        .mode(mode), .btn(btn), .spi(sif.slave), .wifi_en(wifi_en), .wifi_gpio0(wifi_gpio0),
        .prog_active(prog_active), .prog_count(prog_count)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int checks = 0;
    int failures = 0;

    // pin history indexed by posedge number; entries at or before a reset edge read as 1
    logic       a_dtr [0:MAXC-1];
    logic       a_rts [0:MAXC-1];
    logic       a_csn [0:MAXC-1];
    logic       a_sck [0:MAXC-1];
    logic [6:0] a_btn [0:MAXC-1];
    int         cyc = 0;
    int         last_rst = 0;

    logic       m_df, m_rf, m_en, m_io0, m_oe, m_out;
    logic [1:0] m_prev, t_fin, t_ctrl;
    logic [7:0] m_cnt, cap;
    int         hold_end, idx;
    logic [6:0] t_bs;
    logic       t_cs, t_rise, t_act, t_rb, t_trig, t_flip_d, t_flip_r;

    function automatic logic pbit(input int sel, input int i);
        if (i <= last_rst) return 1'b1;
        case (sel)
            0:       return a_dtr[i];
            1:       return a_rts[i];
            2:       return a_csn[i];
            default: return a_sck[i];
        endcase
    endfunction

    function automatic logic [6:0] pbtn(input int i);
        if (i <= last_rst) return 7'h7F;
        return a_btn[i];
    endfunction

    // filtered level flips at edge k when the last C_FILTER synced samples all differ from it
    function automatic logic flips(input int sel, input logic cur, input int k);
        for (int j = 0; j < C_FILTER; j++)
            if (pbit(sel, k - 2 - j) == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic summary_and_fatal(input string why);
        failures++;
        $display("FAIL %s cyc=%0d", why, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench aborted");
    endtask

    initial forever begin
        @(posedge clk_25mhz);
        cyc++;
        if (cyc >= MAXC - 1) summary_and_fatal("cycle_budget");
        a_dtr[cyc] = ftdi_ndtr;
        a_rts[cyc] = ftdi_nrts;
        a_csn[cyc] = sif.spi_csn;
        a_sck[cyc] = sif.spi_sck;
        a_btn[cyc] = btn;
        if (reset) begin
            last_rst = cyc;
            m_df = 1'b1; m_rf = 1'b1; m_prev = 2'b11;
            m_en = 1'b1; m_io0 = 1'b1; m_oe = 1'b0; m_out = 1'b1;
            hold_end = 0; m_cnt = 8'd0; cap = 8'd0; idx = 0;
        end else begin
            t_fin  = {m_df, m_rf};
            t_bs   = pbtn(cyc - 3);
            t_cs   = pbit(2, cyc - 3);
            t_rise = pbit(3, cyc - 3) && !pbit(3, cyc - 4);
            t_act  = (cyc - 1) < hold_end;
            t_rb   = (idx < 8) ? cap[7 - idx] : 1'b0;
            t_trig = (mode == 2'd0) && (m_prev == 2'b11) && (t_fin == 2'b10);

            if (t_act) begin
                m_oe = 1'b1; m_out = m_io0;
            end else if (!t_cs) begin
                m_oe = 1'b1; m_out = t_rb;
            end else begin
                m_oe = 1'b0; m_out = 1'b1;
            end

            case (mode)
                2'd0: begin
                    if (t_fin == 2'b10)      t_ctrl = 2'b01;
                    else if (t_fin == 2'b01) t_ctrl = 2'b10;
                    else                     t_ctrl = 2'b11;
                end
                2'd1:    t_ctrl = {m_rf, m_df};
                2'd2:    t_ctrl = 2'b01;
                default: t_ctrl = 2'b11;
            endcase
            m_en  = t_ctrl[1];
            m_io0 = t_ctrl[0] & t_bs[0];

            if (t_trig) begin
                hold_end = cyc + HOLD_N;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end

            if (t_cs) begin
                cap = {1'b0, t_bs};
                idx = 0;
            end else if (t_rise && idx < 8) begin
                idx++;
            end

            t_flip_d = flips(0, m_df, cyc);
            t_flip_r = flips(1, m_rf, cyc);
            if (t_flip_d) m_df = ~m_df;
            if (t_flip_r) m_rf = ~m_rf;
            m_prev = t_fin;
        end
    end

    initial forever begin
        @(negedge clk_25mhz);
        if (cyc > 0) begin
            checks++;
            if ({wifi_en, wifi_gpio0, sif.sd_d0_out, sif.sd_d0_oe, prog_active, prog_count} !==
                {m_en, m_io0, m_out, m_oe, cyc < hold_end, m_cnt}) begin
                failures++;
                if (failures < 40)
                    $display("FAIL model cyc=%0d got en,io0,out,oe,act=%b%b%b%b%b cnt=%0d exp %b%b%b%b%b cnt=%0d",
                             cyc, wifi_en, wifi_gpio0, sif.sd_d0_out, sif.sd_d0_oe, prog_active, prog_count,
                             m_en, m_io0, m_out, m_oe, cyc < hold_end, m_cnt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25mhz);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    logic [7:0] rd;
    logic       oe_all;

    initial begin
        reset = 1'b1; mode = 2'd0; ftdi_ndtr = 1'b1; ftdi_nrts = 1'b1; btn = 7'h7F;
        sif.spi_csn = 1'b1; sif.spi_sck = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(20);
        chk("reset_en", int'(wifi_en), 1);
        chk("reset_io0", int'(wifi_gpio0), 1);
        chk("reset_oe", int'(sif.sd_d0_oe), 0);
        chk("reset_cnt", int'(prog_count), 0);

        ftdi_nrts = 1'b0; tick(5); ftdi_nrts = 1'b1; tick(30);
        chk("glitch_en", int'(wifi_en), 1);
        chk("glitch_cnt", int'(prog_count), 0);

        ftdi_nrts = 1'b0;
        tick(10);
        chk("entry_early_en", int'(wifi_en), 1);
        chk("entry_early_act", int'(prog_active), 0);
        tick(1);
        chk("entry_en", int'(wifi_en), 0);
        chk("entry_io0", int'(wifi_gpio0), 1);
        chk("entry_act", int'(prog_active), 1);
        chk("entry_cnt", int'(prog_count), 1);
        tick(1);
        chk("hold_oe", int'(sif.sd_d0_oe), 1);
        chk("hold_out", int'(sif.sd_d0_out), 1);

        tick(970);
        ftdi_nrts = 1'b1; tick(20); ftdi_nrts = 1'b0;
        tick(11);
        chk("retrig_cnt", int'(prog_count), 2);
        chk("retrig_act", int'(prog_active), 1);
        tick(HOLD_N - 1);
        chk("retrig_last_act", int'(prog_active), 1);
        tick(1);
        chk("retrig_release", int'(prog_active), 0);
        ftdi_nrts = 1'b1; tick(20);

        btn = 7'b1010011; tick(10);
        sif.spi_csn = 1'b0; tick(10);
        rd = 8'd0; oe_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd = {rd[6:0], sif.sd_d0_out};
            oe_all = oe_all & sif.sd_d0_oe;
            sif.spi_sck = 1'b1; tick(12);
            sif.spi_sck = 1'b0; tick(13);
        end
        chk("spi_byte", int'(rd), 8'h53);
        chk("spi_oe", int'(oe_all), 1);
        sif.spi_csn = 1'b1; tick(10);
        chk("csn_high_oe", int'(sif.sd_d0_oe), 0);
        chk("csn_high_out", int'(sif.sd_d0_out), 1);

        btn = 7'b1010010; mode = 2'd2; tick(10);
        chk("off_en", int'(wifi_en), 0);
        chk("off_io0", int'(wifi_gpio0), 0);

        btn = 7'h7F; mode = 2'd1; ftdi_ndtr = 1'b0; ftdi_nrts = 1'b1; tick(20);
        chk("flash_en", int'(wifi_en), 1);
        chk("flash_io0", int'(wifi_gpio0), 0);
        chk("flash_act", int'(prog_active), 0);
        chk("flash_cnt", int'(prog_count), 2);

        ftdi_ndtr = 1'b1; tick(20); mode = 2'd0; tick(5);
        ftdi_nrts = 1'b0; tick(11);
        chk("hold2_act", int'(prog_active), 1);
        chk("hold2_cnt", int'(prog_count), 3);
        tick(100);
        reset = 1'b1; tick(1);
        chk("rst_hold_act", int'(prog_active), 0);
        chk("rst_hold_cnt", int'(prog_count), 0);
        chk("rst_hold_en", int'(wifi_en), 1);
        chk("rst_hold_oe", int'(sif.sd_d0_oe), 0);
        reset = 1'b0; tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        summary_and_fatal("watchdog");
    end

endmodule
